// File: rtl/output_mem_writer.sv
// Output memory writer: accepts accumulated result beats tagged with
// (channel, y, x), turns the coordinate into an external memory address and
// streams the words out through a small FIFO with a ready/valid write port.
module output_mem_writer #(
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int EXT_MEM_HEIGHT     = 1 << 20,
  parameter int FEATURE_MAP_WIDTH  = 64,
  parameter int FEATURE_MAP_HEIGHT = 64,
  parameter int OUTPUT_NB_CHANNELS = 32,
  parameter int BASE_ADDR          = 0,
  parameter int FIFO_DEPTH         = 4,
  localparam int AW = $clog2(EXT_MEM_HEIGHT),
  localparam int XW = $clog2(FEATURE_MAP_WIDTH),
  localparam int YW = $clog2(FEATURE_MAP_HEIGHT),
  localparam int CW = $clog2(OUTPUT_NB_CHANNELS)
) (
  input  logic                          clk,
  input  logic                          rst_in,
  input  logic                          start,
  input  logic                          out_valid,
  output logic                          out_ready,
  input  logic [ACCUMULATION_WIDTH-1:0] out_data,
  input  logic [XW-1:0]                 out_x,
  input  logic [YW-1:0]                 out_y,
  input  logic [CW-1:0]                 out_ch,
  output logic                          mem_we,
  output logic [AW-1:0]                 mem_addr,
  output logic [ACCUMULATION_WIDTH-1:0] mem_wdata,
  input  logic                          mem_ready,
  output logic                          busy,
  output logic                          done,
  output logic [CW+YW+XW:0]             write_count
);

  localparam int NW    = CW + YW + XW + 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int EW    = AW + ACCUMULATION_WIDTH;
  localparam int TOTAL = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic [PW:0]   fifo_cnt;
  logic          fifo_empty;
  logic          fifo_full;
  logic [NW-1:0] acc_cnt;
  logic          accept;
  logic          pop;
  logic          last_beat;
  logic [AW-1:0] push_addr;
  logic [EW-1:0] head;

  // FIFO status, handshakes and the write port derived from registered state
  always_comb begin
    fifo_cnt   = wr_ptr - rd_ptr;
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
    busy       = (state == S_RUN) || (state == S_DRAIN);
    done       = (state == S_DONE);
    out_ready  = (state == S_RUN) && !fifo_full;
    accept     = out_valid && out_ready;
    mem_we     = busy && !fifo_empty;
    pop        = mem_we && mem_ready;
    last_beat  = accept && (acc_cnt == NW'(TOTAL - 1));
    // address wraps modulo the memory depth; no range error is raised
    push_addr  = AW'(BASE_ADDR) + AW'({out_ch, out_y, out_x});
    head       = fifo_mem[rd_ptr[PW-1:0]];
    // head storage is not reset, so drive zeros whenever no write is offered
    mem_addr   = mem_we ? head[EW-1:ACCUMULATION_WIDTH] : '0;
    mem_wdata  = mem_we ? head[ACCUMULATION_WIDTH-1:0] : '0;
  end

  // FIFO storage: accepted beats are written at the tail
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_mem[wr_ptr[PW-1:0]] <= {push_addr, out_data};
    end
  end

  // Control FSM, FIFO pointers and the accept/commit counters
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      acc_cnt     <= '0;
      write_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_RUN;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            acc_cnt     <= '0;
            write_count <= '0;
          end
        end
        S_RUN: begin
          if (last_beat) state <= S_DRAIN;
        end
        S_DRAIN: begin
          // leave as soon as the final outstanding write commits
          if (fifo_empty || ((fifo_cnt == (PW+1)'(1)) && pop)) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
      // accept and pop are both zero in IDLE, so these never collide with the clear
      if (accept) begin
        wr_ptr  <= wr_ptr + 1'b1;
        acc_cnt <= acc_cnt + 1'b1;
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        write_count <= write_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_output_mem_writer.sv
// Self-checking bench for output_mem_writer using a reduced 4x4x2 layer,
// a 256-word memory and a base address that forces address wrap-around.
module tb_output_mem_writer;

  localparam int ACC  = 16;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int C    = 2;
  localparam int MEMH = 256;
  localparam int BASE = 240;
  localparam int DEP  = 4;
  localparam int TOT  = W * H * C;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        start = 1'b0;
  logic        out_valid = 1'b0;
  logic        out_ready;
  logic [15:0] out_data = '0;
  logic [1:0]  out_x = '0;
  logic [1:0]  out_y = '0;
  logic [0:0]  out_ch = '0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready = 1'b1;
  logic        busy;
  logic        done;
  logic [5:0]  write_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_wr = 0;
  int n_acc = 0;
  bit drv_done;
  logic [23:0] sb [$];

  output_mem_writer #(
    .ACCUMULATION_WIDTH(ACC),
    .EXT_MEM_HEIGHT(MEMH),
    .FEATURE_MAP_WIDTH(W),
    .FEATURE_MAP_HEIGHT(H),
    .OUTPUT_NB_CHANNELS(C),
    .BASE_ADDR(BASE),
    .FIFO_DEPTH(DEP)
  ) dut (
    .clk(clk), .rst_in(rst_in), .start(start),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_x(out_x), .out_y(out_y), .out_ch(out_ch),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .busy(busy), .done(done), .write_count(write_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp_addr(input int ch, input int y, input int x);
    int a;
    a = (BASE + ch * W * H + y * W + x) % MEMH;
    return a[7:0];
  endfunction

  // Scoreboard: push on acceptance, pop and compare on every committed write
  always @(negedge clk) begin
    logic [23:0] e;
    cyc++;
    if (!rst_in) begin
      if (out_valid && out_ready) begin
        sb.push_back({exp_addr(int'(out_ch), int'(out_y), int'(out_x)), out_data});
        n_acc++;
      end
      if (mem_we && mem_ready) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("mem_addr", mem_addr, e[23:16]);
          chk("mem_wdata", mem_wdata, e[15:0]);
        end
        last_wr = cyc;
      end
      if (done) chk("done_lat", cyc - last_wr, 1);
    end
  end

  task automatic send_beat(input int ch, input int y, input int x, input bit rnd);
    bit ok;
    out_ch = ch[0:0];
    out_y = y[1:0];
    out_x = x[1:0];
    out_data = 16'($urandom);
    out_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = out_ready;
      @(posedge clk);
      #1;
      if (rnd) mem_ready = ($urandom_range(0, 3) != 0);
    end
    chk("accept_timeout", ok, 1);
  endtask

  task automatic send_layer(input bit rnd, input int nbeats);
    int n;
    n = 0;
    for (int ch = 0; ch < C; ch++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          if (n < nbeats) begin
            send_beat(ch, y, x, rnd);
            n++;
          end
    out_valid = 1'b0;
    drv_done = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 2000 && !done; k++) @(negedge clk);
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_wcount"}, write_count, TOT);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    logic [7:0]  ha;
    logic [15:0] hd;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    rst_in = 1'b0;
    @(negedge clk);
    chk("rst_out_ready", out_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wcount", write_count, 0);

    // out_valid while idle is never accepted
    @(posedge clk); #1;
    out_valid = 1'b1;
    a0 = n_acc;
    repeat (4) @(negedge clk);
    chk("idle_ready", out_ready, 0);
    chk("idle_accepts", n_acc - a0, 0);
    @(posedge clk); #1;
    out_valid = 1'b0;

    // full layer with random mem_ready and a stray start mid-run
    a0 = n_acc;
    drv_done = 1'b0;
    pulse_start();
    fork
      send_layer(1'b1, TOT);
      begin
        repeat (8) @(posedge clk);
        #2;
        pulse_start();
      end
    join
    mem_ready = 1'b1;
    wait_done("run1");
    chk("run1_accepts", n_acc - a0, TOT);

    // write-side stall: only FIFO_DEPTH beats get in, head held steady
    @(posedge clk); #1;
    mem_ready = 1'b0;
    a0 = n_acc;
    drv_done = 1'b0;
    pulse_start();
    fork
      send_layer(1'b0, TOT);
    join_none
    repeat (3) @(negedge clk);
    chk("stall_we", mem_we, 1);
    ha = mem_addr;
    hd = mem_wdata;
    chk("stall_first_addr", ha, exp_addr(0, 0, 0));
    repeat (7) @(negedge clk);
    chk("stall_accepts", n_acc - a0, DEP);
    chk("stall_ready", out_ready, 0);
    chk("stall_addr_hold", mem_addr, ha);
    chk("stall_data_hold", mem_wdata, hd);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    for (int k = 0; k < 2000 && !drv_done; k++) @(posedge clk);
    chk("stall_driver_done", drv_done, 1);
    wait_done("run2");

    // reset in the middle of a run with three entries queued
    @(posedge clk); #1;
    mem_ready = 1'b0;
    drv_done = 1'b0;
    pulse_start();
    send_layer(1'b0, 3);
    chk("prerst_we", mem_we, 1);
    chk("prerst_busy", busy, 1);
    rst_in = 1'b1;
    @(posedge clk); #1;
    rst_in = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_we", mem_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_wcount", write_count, 0);
    chk("midrst_ready", out_ready, 0);
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_idle_we", mem_we, 0);

    // clean restart after reset
    @(posedge clk); #1;
    a0 = n_acc;
    drv_done = 1'b0;
    pulse_start();
    send_layer(1'b0, TOT);
    wait_done("run3");
    chk("run3_accepts", n_acc - a0, TOT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_mem_writer.md
OUTPUT_MEM_WRITER -- requirements
Module: output_mem_writer

Interface
REQ-001 SHALL have parameter ACCUMULATION_WIDTH, default 32, output-word width.
REQ-002 SHALL have parameter EXT_MEM_HEIGHT, default 1<<20, external memory depth in words; address width AW = log2(EXT_MEM_HEIGHT).
REQ-003 SHALL have parameters FEATURE_MAP_WIDTH 64, FEATURE_MAP_HEIGHT 64, OUTPUT_NB_CHANNELS 32; all powers of two; XW/YW/CW = log2 of each.
REQ-004 SHALL have parameter BASE_ADDR, default 0, first word of the output region; parameter FIFO_DEPTH, default 4, power of two.
REQ-005 clk  input  1  rising-edge clock, sole clock.
REQ-006 rst_in  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse beginning a layer write-back.
REQ-008 out_valid  input  1  producer output beat valid.
REQ-009 out_ready  output  1  beat accepted when out_valid && out_ready.
REQ-010 out_data  input  ACCUMULATION_WIDTH  accumulated result.
REQ-011 out_x / out_y / out_ch  input  XW / YW / CW  coordinates of out_data.
REQ-012 mem_we  output  1  write strobe to external memory.
REQ-013 mem_addr  output  AW  write address.
REQ-014 mem_wdata  output  ACCUMULATION_WIDTH  write data.
REQ-015 mem_ready  input  1  memory accepts the write this cycle when mem_we && mem_ready.
REQ-016 busy  output  1  high in RUN or DRAIN.
REQ-017 done  output  1  one-cycle pulse when all words written.
REQ-018 write_count  output  CW+YW+XW+1  words committed to memory this layer.

Function
REQ-019 SHALL implement FSM IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE: out_ready=0; start -> RUN and clear write_count, accept counter, FIFO.
REQ-021 RUN: out_ready = !fifo_full; accepted beats push {addr, data} into FIFO.
REQ-022 Address SHALL be BASE_ADDR + {out_ch, out_y, out_x}, modulo 2^AW (wrap, no error), computed before the FIFO push.
REQ-023 RUN -> DRAIN in the cycle the accept counter reaches W*H*C; out_ready=0 from then on.
REQ-024 DRAIN -> DONE when FIFO empty and no write pending; DONE lasts one cycle with done=1, then IDLE.
REQ-025 mem_we = !fifo_empty in RUN/DRAIN; mem_addr/mem_wdata = FIFO head; pop and write_count+1 on mem_we && mem_ready.
REQ-026 Latency: beat accepted at edge n SHALL present mem_we at cycle n+1 earliest (FIFO empty, registered head).
REQ-027 Push and pop same cycle SHALL leave occupancy unchanged; full with simultaneous pop still holds out_ready=0 that cycle (out_ready depends on registered full only).
REQ-028 mem_addr/mem_wdata SHALL stay stable while mem_we=1 and mem_ready=0.
REQ-029 start outside IDLE SHALL be ignored.
REQ-030 Writes SHALL leave in acceptance order; no reordering, no merging of duplicate coordinates.

Reset
REQ-031 rst_in at any edge, including mid-RUN/DRAIN, SHALL force IDLE, empty FIFO, counters 0.
REQ-032 Reset values: out_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, write_count=0.
REQ-033 Pending FIFO entries at reset SHALL be discarded, never written.

Verification
REQ-034 Reset, start, 64*64*32 beats raster order, mem_ready=1 -> 131072 writes, addr 0..131071 in order, done one cycle after last write, write_count=131072.
REQ-035 BASE_ADDR=0xF0000, beat (ch=31,y=63,x=63) -> mem_addr=0xF0000+0x1FFFF wrapped = 0x0FFFF.
REQ-036 mem_ready=0 for 10 cycles, continuous out_valid -> exactly 4 beats accepted, out_ready=0 after, addr/data held; mem_ready=1 -> all drain in order.
REQ-037 rst_in mid-RUN with 3 FIFO entries -> next cycle mem_we=0, busy=0, write_count=0; new start restarts cleanly.
REQ-038 out_valid before start and start during RUN -> no acceptance in IDLE, second start no effect on counters.
